dlfloat_dot_sequencer: RTL and testbench



---
 rtl/dlfloat_dot_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dlfloat_dot_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_dot_sequencer.sv
// Command sequencer for a DLFloat16 MAC: clears the accumulator, streams operand
// pairs one cycle each, waits for the MAC pipeline to drain, then returns the sum.
module dlfloat_dot_sequencer #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic             mac_clr,
    input  logic [15:0]      mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             res_inf,
    output logic             busy
);

    localparam int WAIT_W = $clog2(MAC_LAT + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state_r, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_r, cnt_d;
    logic [WAIT_W-1:0]  wait_r, wait_d;
    logic [15:0]        mac_a_d, mac_b_d, res_data_d;
    logic               mac_clr_d, in_ready_d, res_valid_d, res_inf_d, busy_d;
    logic               hs;
    logic [LEN_W-1:0]   cnt_inc;

    function automatic logic is_inf(input logic [15:0] v);
        return (v == 16'hFFFF);
    endfunction

    assign hs      = in_valid & in_ready & (state_r == FEED);
    assign cnt_inc = cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};

    // Next-state and next-output computation; all outputs are registered below.
    always_comb begin
        state_d     = state_r;
        len_d       = len_q;
        cnt_d       = cnt_r;
        wait_d      = wait_r;
        mac_a_d     = 16'h0000;
        mac_b_d     = 16'h0000;
        mac_clr_d   = 1'b0;
        res_valid_d = res_valid;
        res_data_d  = res_data;
        res_inf_d   = res_inf;
        if (abort) begin
            state_d     = IDLE;
            mac_clr_d   = 1'b1;
            res_valid_d = 1'b0;
            cnt_d       = {LEN_W{1'b0}};
            wait_d      = {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_d     = cfg_len;
                        res_inf_d = 1'b0;
                        cnt_d     = {LEN_W{1'b0}};
                        wait_d    = {WAIT_W{1'b0}};
                        if (cfg_len == {LEN_W{1'b0}}) begin
                            state_d     = DONE;
                            res_data_d  = 16'h0000;
                            res_valid_d = 1'b1;
                        end else begin
                            state_d   = CLEAR;
                            mac_clr_d = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CLEAR: begin
                    if (wait_r == WAIT_W'(MAC_LAT - 1)) begin
                        state_d = FEED;
                        wait_d  = {WAIT_W{1'b0}};
                    end else begin
                        mac_clr_d = 1'b1;
                        wait_d    = wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                FEED: begin
                    if (hs) begin
                        mac_a_d   = in_a;
                        mac_b_d   = in_b;
                        cnt_d     = cnt_inc;
                        res_inf_d = res_inf | is_inf(in_a) | is_inf(in_b);
                        if (cnt_inc == len_q) begin
                            state_d = DRAIN;
                            wait_d  = {WAIT_W{1'b0}};
                        end else begin
                            state_d = FEED;
                        end
                    end else begin
                        state_d = FEED;
                    end
                end
                DRAIN: begin
                    // The final product reaches mac_acc MAC_LAT edges after its handshake.
                    if (wait_r == WAIT_W'(MAC_LAT)) begin
                        res_data_d  = mac_acc;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        wait_d = wait_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d     = IDLE;
                        res_valid_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            endcase
        end
        in_ready_d = (state_d == FEED);
        busy_d     = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            len_q     <= {LEN_W{1'b0}};
            cnt_r     <= {LEN_W{1'b0}};
            wait_r    <= {WAIT_W{1'b0}};
            mac_a     <= 16'h0000;
            mac_b     <= 16'h0000;
            mac_clr   <= 1'b0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            res_inf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_d;
            len_q     <= len_d;
            cnt_r     <= cnt_d;
            wait_r    <= wait_d;
            mac_a     <= mac_a_d;
            mac_b     <= mac_b_d;
            mac_clr   <= mac_clr_d;
            in_ready  <= in_ready_d;
            res_valid <= res_valid_d;
            res_data  <= res_data_d;
            res_inf   <= res_inf_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_dlfloat_dot_sequencer.sv
// Directed bench for dlfloat_dot_sequencer with a small behavioural DLFloat16 MAC
// (multiplier register + accumulator register) closing the loop on mac_acc.
module tb_dlfloat_dot_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cfg_len = 8'd0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0000;
    logic [15:0] in_b = 16'h0000;
    logic [15:0] mac_a, mac_b, mac_acc, res_data;
    logic        mac_clr, res_valid, res_inf, busy;
    logic        res_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    int act_cnt = 0;
    int c0, a0;

    dlfloat_dot_sequencer #(.LEN_W(8), .MAC_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_inf(res_inf), .busy(busy)
    );

    always #5 clk = ~clk;

    // DLFloat16: 1 sign, 6 exponent (bias 31), 9 mantissa; 16'hFFFF is the inf/NaN code.
    function automatic real dl2r(input logic [15:0] v);
        real m;
        int  e;
        if (v[14:0] == 15'd0) return 0.0;
        m = 1.0 + real'(v[8:0]) / 512.0;
        e = int'(v[14:9]) - 31;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return v[15] ? -m : m;
    endfunction

    function automatic logic [15:0] r2dl(input real v);
        real m;
        int  e;
        if (v <= 0.0) return 16'h0000;
        m = v;
        e = 31;
        while (m >= 2.0 && e < 63) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > 0) begin m = m * 2.0; e--; end
        return {1'b0, 6'(e), 9'(int'((m - 1.0) * 512.0))};
    endfunction

    function automatic logic [15:0] dl_mul(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        return r2dl(dl2r(a) * dl2r(b));
    endfunction

    function automatic logic [15:0] dl_add(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        return r2dl(dl2r(a) + dl2r(b));
    endfunction

    logic [15:0] prod_r, acc_r;
    assign mac_acc = acc_r;

    // Behavioural MAC: product register then accumulator register.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_r <= 16'h0000;
            acc_r  <= 16'h0000;
        end else if (mac_clr) begin
            prod_r <= 16'h0000;
            acc_r  <= 16'h0000;
        end else begin
            prod_r <= dl_mul(mac_a, mac_b);
            acc_r  <= dl_add(acc_r, prod_r);
        end
    end

    // Activity counters for clear pulses and non-zero operands.
    always @(posedge clk) begin
        if (mac_clr === 1'b1) clr_cnt <= clr_cnt + 1;
        if (mac_a !== 16'h0000) act_cnt <= act_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [7:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) chk("feed_timeout", 32'(n), 32'd0);
        tick();
        in_valid = 1'b0;
        in_a = 16'h0000;
        in_b = 16'h0000;
    endtask

    task automatic wait_res(input string tag, input int expect_cyc);
        int n = 0;
        while (res_valid !== 1'b1 && n < 20) begin tick(); n++; end
        chk(tag, 32'(n), 32'(expect_cyc));
    endtask

    task automatic pop();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("pop_valid", {31'd0, res_valid}, 32'd0);
        chk("pop_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_mac_a", {16'd0, mac_a}, 32'h0);
        chk("rst_mac_clr", {31'd0, mac_clr}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Length 2, back-to-back 1.0*1.0 pairs -> 2.0
        c0 = clr_cnt;
        cmd(8'd2);
        chk("t1_clr", {31'd0, mac_clr}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        feed(16'h3E00, 16'h3E00);
        chk("t1_mac_a1", {16'd0, mac_a}, 32'h3E00);
        feed(16'h3E00, 16'h3E00);
        chk("t1_ready_drop", {31'd0, in_ready}, 32'd0);
        wait_res("t1_lat", 3);
        chk("t1_data", {16'd0, res_data}, 32'h4000);
        chk("t1_inf", {31'd0, res_inf}, 32'd0);
        chk("t1_clr_cycles", 32'(clr_cnt - c0), 32'd2);
        pop();

        // Length 3, two idle cycles between (1.0,2.0) pairs -> 6.0
        cmd(8'd3);
        for (int p = 0; p < 3; p++) begin
            feed(16'h3E00, 16'h4000);
            chk("t2_mac_b", {16'd0, mac_b}, 32'h4000);
            if (p < 2) begin
                tick();
                chk("t2_gap1", {16'd0, mac_a}, 32'h0);
                tick();
                chk("t2_gap2", {16'd0, mac_a}, 32'h0);
            end
        end
        wait_res("t2_lat", 3);
        chk("t2_data", {16'd0, res_data}, 32'h4300);
        pop();

        // Zero length goes straight to DONE with a zero result
        c0 = clr_cnt;
        a0 = act_cnt;
        cmd(8'd0);
        chk("t3_valid", {31'd0, res_valid}, 32'd1);
        chk("t3_data", {16'd0, res_data}, 32'h0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        pop();
        chk("t3_no_clr", 32'(clr_cnt - c0), 32'd0);
        chk("t3_no_act", 32'(act_cnt - a0), 32'd0);

        // Inf operand sets res_inf; next command clears it
        cmd(8'd1);
        feed(16'hFFFF, 16'h3E00);
        wait_res("t4_lat", 3);
        chk("t4_inf", {31'd0, res_inf}, 32'd1);
        chk("t4_data", {16'd0, res_data}, 32'hFFFF);
        pop();
        cmd(8'd1);
        chk("t4_inf_clr", {31'd0, res_inf}, 32'd0);
        feed(16'h3E00, 16'h4000);
        wait_res("t4b_lat", 3);
        chk("t4b_data", {16'd0, res_data}, 32'h4000);
        pop();

        // Abort after 1 of 4 pairs; start during FEED ignored
        cmd(8'd4);
        feed(16'h4000, 16'h4000);
        start = 1'b1;
        cfg_len = 8'd1;
        tick();
        start = 1'b0;
        chk("t5_start_ign", {31'd0, in_ready}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_clr", {31'd0, mac_clr}, 32'd1);
        chk("t5_abort_busy", {31'd0, busy}, 32'd0);
        chk("t5_abort_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_abort_mac_a", {16'd0, mac_a}, 32'h0);
        tick();
        chk("t5_clr_once", {31'd0, mac_clr}, 32'd0);
        cmd(8'd1);
        feed(16'h3E00, 16'h3E00);
        wait_res("t5_lat", 3);
        chk("t5_data", {16'd0, res_data}, 32'h3E00);

        // Result held while consumer stalls
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_hold_valid", {31'd0, res_valid}, 32'd1);
            chk("t6_hold_data", {16'd0, res_data}, 32'h3E00);
            chk("t6_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        pop();

        // Reset during DRAIN
        cmd(8'd1);
        feed(16'hFFFF, 16'h3E00);
        chk("t7_pre_mac_a", {16'd0, mac_a}, 32'hFFFF);
        rst = 1'b1;
        #1;
        chk("t7_mac_a", {16'd0, mac_a}, 32'h0);
        chk("t7_busy", {31'd0, busy}, 32'd0);
        chk("t7_inf", {31'd0, res_inf}, 32'd0);
        chk("t7_data", {16'd0, res_data}, 32'h0);
        chk("t7_valid", {31'd0, res_valid}, 32'd0);
        tick();
        #3;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t7_no_result", {31'd0, res_valid}, 32'd0);
        chk("t7_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
